// File: rtl/branch_resolver.sv
// Resolution end of the branch-prediction loop: queues fetch-time predictions in order,
// checks each against the execute outcome, emits training/flush pulses and keeps perf counters.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic [ADDR_W-1:0] pred_fallthrough,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              outcome_valid,
  output logic              outcome_taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count,
  output logic              underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic              taken_mem  [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic [ADDR_W-1:0] fall_mem   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              outcome_valid_q, outcome_valid_d;
  logic              outcome_taken_q, outcome_taken_d;
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic              underflow_q, underflow_d;

  logic              full, empty, push, pop, mis;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target, head_fall;

  assign full        = (occ_q == OCC_W'(DEPTH));
  assign empty       = (occ_q == '0);
  assign pred_ready  = !full;
  assign push        = pred_valid && !full;
  assign pop         = res_valid && !empty;
  assign head_taken  = taken_mem[rd_ptr_q];
  assign head_target = target_mem[rd_ptr_q];
  assign head_fall   = fall_mem[rd_ptr_q];
  // A taken branch is also wrong when it went to a different target than predicted.
  assign mis = pop && ((res_taken != head_taken) ||
                       (res_taken && (res_target != head_target)));

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    occ_d           = occ_q;
    outcome_valid_d = pop;
    // Direction and redirect PC are zeroed outside their pulses so idle outputs stay quiet.
    outcome_taken_d = pop && res_taken;
    mispredict_d    = mis;
    redirect_pc_d   = '0;
    branch_cnt_d    = sat_inc(branch_cnt_q, pop);
    mispred_cnt_d   = sat_inc(mispred_cnt_q, mis);
    underflow_d     = underflow_q || (res_valid && empty);
    if (mis) begin
      redirect_pc_d = res_taken ? res_target : head_fall;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      occ_d         = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      occ_q           <= '0;
      outcome_valid_q <= 1'b0;
      outcome_taken_q <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      branch_cnt_q    <= '0;
      mispred_cnt_q   <= '0;
      underflow_q     <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
      outcome_valid_q <= outcome_valid_d;
      outcome_taken_q <= outcome_taken_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      branch_cnt_q    <= branch_cnt_d;
      mispred_cnt_q   <= mispred_cnt_d;
      underflow_q     <= underflow_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (push && !mis) begin
      taken_mem[wr_ptr_q]  <= pred_taken;
      target_mem[wr_ptr_q] <= pred_target;
      fall_mem[wr_ptr_q]   <= pred_fallthrough;
    end
  end

  assign outcome_valid    = outcome_valid_q;
  assign outcome_taken    = outcome_taken_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized, self-checking bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int SCNT_W = 3;
  localparam int VW     = 3 + ADDR_W + 2 * CNT_W + 2;

  typedef struct packed {
    logic              tk;
    logic [ADDR_W-1:0] tg;
    logic [ADDR_W-1:0] ft;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              pred_valid = 1'b0, pred_taken = 1'b0;
  logic [ADDR_W-1:0] pred_target = '0, pred_fallthrough = '0;
  logic              res_valid = 1'b0, res_taken = 1'b0;
  logic [ADDR_W-1:0] res_target = '0;

  logic              rdy, ov, ot, mp, uf;
  logic [ADDR_W-1:0] rpc;
  logic [CNT_W-1:0]  bc, mc;
  logic              s_rdy, s_ov, s_ot, s_mp, s_uf;
  logic [ADDR_W-1:0] s_rpc;
  logic [SCNT_W-1:0] s_bc, s_mc;

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthrough(pred_fallthrough), .pred_ready(rdy),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .outcome_valid(ov), .outcome_taken(ot), .mispredict(mp), .redirect_pc(rpc),
    .branch_count(bc), .mispredict_count(mc), .underflow_err(uf));

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(SCNT_W)) dut_s (
    .clock(clock), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthrough(pred_fallthrough), .pred_ready(s_rdy),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .outcome_valid(s_ov), .outcome_taken(s_ot), .mispredict(s_mp), .redirect_pc(s_rpc),
    .branch_count(s_bc), .mispredict_count(s_mc), .underflow_err(s_uf));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;

  ent_t              mq[$];
  logic              exp_ov, exp_ot, exp_mp, exp_uf;
  logic [ADDR_W-1:0] exp_rpc;
  int                exp_bc, exp_mc, exp_bc_s, exp_mc_s;

  function automatic logic [VW-1:0] obs_vec();
    return {ov, ot, mp, rpc, bc, mc, uf, rdy};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic r;
    r = (mq.size() < DEPTH);
    return {exp_ov, exp_ot, exp_mp, exp_rpc, CNT_W'(exp_bc), CNT_W'(exp_mc), exp_uf, r};
  endfunction

  function automatic void model_clear();
    mq.delete();
    exp_ov = 0; exp_ot = 0; exp_mp = 0; exp_uf = 0; exp_rpc = '0;
    exp_bc = 0; exp_mc = 0; exp_bc_s = 0; exp_mc_s = 0;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    pred_valid = 0; res_valid = 0;
    @(posedge clock); #1;
    model_clear();
    reset_n = 1'b1;
  endtask

  // Applies one cycle of stimulus and advances the reference model by one clock.
  task automatic step(input logic pv, input logic pt, input logic [ADDR_W-1:0] ptg,
                      input logic [ADDR_W-1:0] pf, input logic rv, input logic rt,
                      input logic [ADDR_W-1:0] rtg);
    bit push, pop, mis, empty;
    ent_t e;
    logic [ADDR_W-1:0] good;
    pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthrough = pf;
    res_valid = rv; res_taken = rt; res_target = rtg;
    empty = (mq.size() == 0);
    push  = pv && (mq.size() < DEPTH);
    pop   = rv && !empty;
    mis = 0; good = '0; e = '0;
    if (pop) begin
      e = mq[0];
      mis  = (rt != e.tk) || (rt && (rtg != e.tg));
      good = rt ? rtg : e.ft;
    end
    @(posedge clock); #1;
    if (pop) void'(mq.pop_front());
    if (mis) mq.delete();
    else if (push) mq.push_back('{tk: pt, tg: ptg, ft: pf});
    exp_ov  = pop;
    exp_ot  = pop && rt;
    exp_mp  = mis;
    exp_rpc = mis ? good : '0;
    if (pop && exp_bc < 65535) exp_bc++;
    if (mis && exp_mc < 65535) exp_mc++;
    if (pop && exp_bc_s < 7) exp_bc_s++;
    if (mis && exp_mc_s < 7) exp_mc_s++;
    if (rv && empty) exp_uf = 1;
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    if (obs_vec() !== VW'(1)) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), VW'(1));
    end
    n_vec++;
    if ({s_bc, s_mc, s_uf} !== '0) begin
      n_fail++; $display("FAIL reset_small: got %h want 0", {s_bc, s_mc, s_uf});
    end
    n_vec++;
  endtask

  task automatic test_correct();
    step(1, 1, 32'h100, 32'h4, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h100);
    if ({ov, ot, mp} !== 3'b110 || bc !== 16'd1 || mc !== 16'd0) begin
      n_fail++; $display("FAIL correct_taken: got ov%b ot%b mp%b bc%0d mc%0d want 1 1 0 1 0", ov, ot, mp, bc, mc);
    end
    n_vec++;
    idle();
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pulse_one_cycle: got %h want %h", obs_vec(), exp_vec());
    end
    n_vec++;
  endtask

  task automatic test_dir_mispredict();
    step(1, 0, 32'h900, 32'h44, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h200);
    if (mp !== 1'b1 || rpc !== 32'h200 || mc !== 16'd1 || ov !== 1'b1) begin
      n_fail++; $display("FAIL dir_mispredict: got mp%b rpc%h mc%0d ov%b want 1 200 1 1", mp, rpc, mc, ov);
    end
    n_vec++;
  endtask

  task automatic test_fallthrough();
    step(1, 1, 32'h300, 32'h24, 0, 0, '0);
    step(0, 0, '0, '0, 1, 0, 32'h300);
    if (mp !== 1'b1 || rpc !== 32'h24 || ot !== 1'b0) begin
      n_fail++; $display("FAIL fallthrough_redirect: got mp%b rpc%h ot%b want 1 24 0", mp, rpc, ot);
    end
    n_vec++;
  endtask

  task automatic test_wrong_target();
    step(1, 1, 32'h300, 32'h24, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h304);
    if (mp !== 1'b1 || rpc !== 32'h304 || mc !== 16'd3) begin
      n_fail++; $display("FAIL wrong_target: got mp%b rpc%h mc%0d want 1 304 3", mp, rpc, mc);
    end
    n_vec++;
  endtask

  task automatic test_full();
    logic              tk[5];
    logic [ADDR_W-1:0] tg[5];
    for (int i = 0; i < 5; i++) begin
      tk[i] = i[0];
      tg[i] = 32'h400 + 32'(16 * i);
    end
    for (int i = 0; i < 4; i++) step(1, tk[i], tg[i], tg[i] + 4, 0, 0, '0);
    if (rdy !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b want 0", rdy);
    end
    n_vec++;
    // Fetch holds pred_valid while full; the pop frees a slot but the push is refused.
    step(1, tk[4], tg[4], tg[4] + 4, 1, tk[0], tg[0]);
    if ({ov, ot, mp, rdy} !== {1'b1, tk[0], 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL full_pop: got %b want %b", {ov, ot, mp, rdy}, {1'b1, tk[0], 1'b0, 1'b1});
    end
    n_vec++;
    step(1, tk[4], tg[4], tg[4] + 4, 1, tk[1], tg[1]);
    if (obs_vec() !== exp_vec() || mq.size() != 3) begin
      n_fail++; $display("FAIL push_pop_same: got %h want %h", obs_vec(), exp_vec());
    end
    n_vec++;
    for (int i = 2; i < 5; i++) begin
      step(0, 0, '0, '0, 1, tk[i], tg[i]);
      if ({ov, ot, mp} !== {1'b1, tk[i], 1'b0}) begin
        n_fail++; $display("FAIL in_order_%0d: got %b want %b", i, {ov, ot, mp}, {1'b1, tk[i], 1'b0});
      end
      n_vec++;
    end
  endtask

  task automatic test_flush_underflow();
    for (int i = 0; i < 3; i++) step(1, 1, 32'h500, 32'h504, 0, 0, '0);
    step(1, 1, 32'h600, 32'h604, 1, 0, '0);
    if ({mp, rpc, rdy} !== {1'b1, 32'h504, 1'b1}) begin
      n_fail++; $display("FAIL flush: got mp%b rpc%h rdy%b want 1 504 1", mp, rpc, rdy);
    end
    n_vec++;
    step(0, 0, '0, '0, 1, 1, 32'h600);
    if ({ov, mp, uf} !== 3'b001) begin
      n_fail++; $display("FAIL underflow: got ov%b mp%b uf%b want 0 0 1", ov, mp, uf);
    end
    n_vec++;
    idle();
    if (uf !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL underflow_sticky: got %h want %h", obs_vec(), exp_vec());
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 32'h1000 + 32'(4 * ($urandom % 2)), $urandom,
           ($urandom % 2) == 1, 1'($urandom), 32'h1000 + 32'(4 * ($urandom % 2)));
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 1, 32'h700, 32'h704, 0, 0, '0);
    step(1, 1, 32'h700, 32'h704, 1, 1, 32'h700);
    reset_n = 1'b0;
    pred_valid = 1; res_valid = 1; res_taken = 0;
    @(posedge clock); #1;
    model_clear();
    if (obs_vec() !== VW'(1) || {s_bc, s_mc, s_uf} !== '0) begin
      n_fail++; $display("FAIL reset_midrun: got %h want %h", obs_vec(), VW'(1));
    end
    n_vec++;
    reset_n = 1'b1;
    pred_valid = 0;
    step(0, 0, '0, '0, 1, 1, 32'h700);
    if ({ov, uf} !== 2'b01) begin
      n_fail++; $display("FAIL reset_cleared_fifo: got %b want 01", {ov, uf});
    end
    n_vec++;
  endtask

  task automatic test_small_sat();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'h600, 32'h604, 0, 0, '0);
      step(0, 0, '0, '0, 1, 0, '0);
    end
    if (s_bc !== 3'd7 || s_mc !== 3'd7 || s_bc !== SCNT_W'(exp_bc_s) || s_mc !== SCNT_W'(exp_mc_s)) begin
      n_fail++; $display("FAIL small_sat: got bc%0d mc%0d want 7 7", s_bc, s_mc);
    end
    n_vec++;
    if (bc !== 16'd10 || mc !== 16'd10) begin
      n_fail++; $display("FAIL count_10: got bc%0d mc%0d want 10 10", bc, mc);
    end
    n_vec++;
  endtask

  task automatic test_saturation();
    do_reset();
    step(1, 1, 32'h700, 32'h704, 0, 0, '0);
    for (int i = 0; i < 65540; i++) step(1, 1, 32'h700, 32'h704, 1, 1, 32'h700);
    if (bc !== 16'hFFFF || mc !== 16'h0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL branch_sat: got bc%h mc%h want ffff 0", bc, mc);
    end
    n_vec++;
    step(0, 0, '0, '0, 1, 1, 32'h700);
    if (bc !== 16'hFFFF) begin
      n_fail++; $display("FAIL branch_sat_hold: got %h want ffff", bc);
    end
    n_vec++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_fallthrough();
    test_wrong_target();
    test_full();
    test_flush_underflow();
    test_random();
    test_reset_midrun();
    test_small_sat();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
